axis_cpu_prog_ctrl: RTL and testbench
=====================================

# axis_cpu_prog_ctrl

Programming and run-control sequencer for the AXI-Stream BPF-style CPU. It decodes the unbackpressured `cmd_in` command stream and acts on the CPU core in four ways: it writes instruction and immediate memories, holds the core in reset, gates instruction fetch for single-stepping or free-running, and returns register and status reads on `cmd_out`. It sits beside the controller/datapath pair and drives their `hold_in_rst`, `inst_rd_en` gate and memory write ports.

## Interface
- `CODE_ADDR_WIDTH`, 10: instruction/immediate memory address width.
- `clk` in 1: sole clock.
- `rst` in 1: reset, asynchronous, active-low.
- `cmd_in_TDATA` in 32, `cmd_in_TVALID` in 1: command beats. There is no TREADY; every valid beat is consumed.
- `cmd_out_TDATA` out 32, `cmd_out_TVALID` out 1: responses. There is no TREADY.
- `hold_in_rst` out 1: holds the controller and datapath in reset.
- `cpu_en` out 1: ANDed with the controller's `inst_rd_en`.
- `inst_fetch` in 1: pulse when a gated fetch occurs (`inst_rd_en && cpu_en`).
- `inst_wr_en` out 1, `inst_wr_addr` out CODE_ADDR_WIDTH, `inst_wr_data` out 8: instruction memory write port.
- `imm_wr_en` out 1, `imm_wr_addr` out CODE_ADDR_WIDTH, `imm_wr_data` out 32: immediate memory write port.
- `reg_rd_en` out 1, `reg_rd_addr` out 4: regfile read request.
- `reg_rd_data` in 32: regfile read data, valid one cycle after `reg_rd_en`.

## Operation
- Opcode is `cmd_in_TDATA[31:28]`.
  - 0 NOP.
  - 1 SET_ADDR: `addr <= [CODE_ADDR_WIDTH-1:0]`.
  - 2 WR_INST: write `[7:0]` at `addr`, then `addr++`.
  - 3 WR_IMM: header only; the next valid beat is the 32-bit immediate, written at `addr`, then `addr++`.
  - 4 HOLD: `hold_in_rst <= [0]`.
  - 5 STEP: `step_cnt <= [15:0]`.
  - 6 RUN: `run <= [0]`. RUN 0 also clears `step_cnt`.
  - 7 READ_REG: read register `[3:0]`.
  - 8 READ_STATUS: reply `{hold_in_rst, run, err, 13'b0, step_cnt}`, then clear `err`.
  - 9–15 are illegal: no action, set `err`.
- FSM states:
  - IDLE: a WR_IMM beat moves to IMM_DATA.
  - IMM_DATA: the next valid beat is treated as data (never decoded) and the FSM returns to IDLE.
- Memory writes (WR_INST and WR_IMM data) are legal only while `hold_in_rst=1`. Otherwise the write is dropped, `addr` is unchanged and `err` is set.
- `addr` wraps modulo 2^CODE_ADDR_WIDTH.
- `cpu_en = !hold_in_rst && (run || step_cnt != 0)`.
  - `inst_fetch` with `!run && step_cnt != 0` decrements `step_cnt`.
  - A STEP load in the same cycle as `inst_fetch` wins; there is no decrement that cycle.
  - STEP 0 clears `step_cnt`.
- HOLD 1 clears `run` and `step_cnt`.
- Reset values:
  - `hold_in_rst=1`.
  - `cpu_en=0`, `run=0`, `step_cnt=0`, `err=0`, `addr=0`, FSM in IDLE.
  - All write/read enables 0, `cmd_out_TVALID=0`, all data outputs 0.
- Reset asserted mid-IMM_DATA returns the FSM to IDLE and discards the pending header.

## Timing
- Command beat accepted at cycle N.
- Register effects (`hold_in_rst`, `run`, `step_cnt`, `addr`) are visible at N+1.
- Memory write strobes assert at N+1 for exactly one cycle. For WR_IMM, N is the data beat.
- READ_REG: `reg_rd_en` at N+1, `reg_rd_data` sampled at N+2, `cmd_out_TVALID` high at N+3 for one cycle.
- Every response uses a single 3-stage response pipeline, so replies appear at N+3 in command order. Back-to-back commands produce back-to-back replies and can never collide.
- Throughput is one command per cycle, including consecutive READ_REGs.

## Configuration
- `AXIS_CPU_PROG_ACK_EN` defined:
  - Every accepted non-read beat (including WR_IMM data) produces an ack at N+3: `{4'hA, opcode, 7'b0, err, 16'(addr)}`.
  - READ_REG and READ_STATUS reply with data only.
- Undefined: only READ_REG and READ_STATUS produce `cmd_out` beats. The ack pipeline stage logic is not built.

## Structure
- Shared package `axis_cpu_prog_pkg` holds:
  - opcode localparams;
  - the FSM state enum (IDLE, IMM_DATA);
  - the ack tag `4'hA`;
  - the status field positions.
- Sub-module `axis_cpu_prog_resp`: the 3-stage response pipeline that muxes register data, status and acks.
- The decode, FSM and counters stay in the top module.

## Test plan
- Reset, then SET_ADDR 5, WR_INST 0x3C, WR_INST 0x11 → `inst_wr` at addr 5 = 0x3C, then addr 6 = 0x11; `cpu_en` stays 0.
- WR_IMM then data 0xDEADBEEF on the next beat → `imm_wr_en` one cycle, addr 0, data 0xDEADBEEF. A beat of 0x4000_0000 sent as data is written, not decoded.
- HOLD 0, WR_INST 0x55 → no `inst_wr_en`. READ_STATUS then replies with `err=1` at N+3; a second READ_STATUS shows `err=0`.
- HOLD 0, STEP 3, drive `inst_fetch` every cycle → `cpu_en` high for exactly 3 fetches, then `step_cnt=0`. STEP 2 coinciding with a fetch gives `step_cnt=2`.
- READ_REG 1, READ_REG 2, NOP back-to-back, with `reg_rd_data` = 0x11 and then 0x22 → `cmd_out` 0x11 at N+3 and 0x22 at N+4. With `AXIS_CPU_PROG_ACK_EN`, the NOP ack follows at N+5.
- RUN 1, then assert `rst` low mid-run → `hold_in_rst=1`, `cpu_en=0`, `cmd_out_TVALID=0` immediately (asynchronously).

Source files
------------

// File: rtl/axis_cpu_prog_pkg.sv
// Shared opcodes, FSM state, response payload and word-formatting helpers
// for the BPF-style CPU programming/run-control sequencer.
package axis_cpu_prog_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STEP_W  = 16;
  localparam int unsigned RADDR_W = 4;

  localparam logic [3:0] OP_NOP         = 4'd0;
  localparam logic [3:0] OP_SET_ADDR    = 4'd1;
  localparam logic [3:0] OP_WR_INST     = 4'd2;
  localparam logic [3:0] OP_WR_IMM      = 4'd3;
  localparam logic [3:0] OP_HOLD        = 4'd4;
  localparam logic [3:0] OP_STEP        = 4'd5;
  localparam logic [3:0] OP_RUN         = 4'd6;
  localparam logic [3:0] OP_READ_REG    = 4'd7;
  localparam logic [3:0] OP_READ_STATUS = 4'd8;

  localparam logic [3:0] ACK_TAG = 4'hA;

  localparam int unsigned STATUS_HOLD_BIT = 31;
  localparam int unsigned STATUS_RUN_BIT  = 30;
  localparam int unsigned STATUS_ERR_BIT  = 29;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IMM_DATA = 1'b1
  } state_e;

  typedef enum logic {
    RESP_DATA = 1'b0,
    RESP_REG  = 1'b1
  } resp_kind_e;

  typedef struct packed {
    logic              valid;
    resp_kind_e        kind;
    logic [DATA_W-1:0] data;
  } resp_req_t;

  function automatic logic [DATA_W-1:0] status_word(input logic hold, input logic run,
                                                    input logic err,
                                                    input logic [STEP_W-1:0] step);
    logic [DATA_W-1:0] w;
    w = '0;
    w[STATUS_HOLD_BIT] = hold;
    w[STATUS_RUN_BIT]  = run;
    w[STATUS_ERR_BIT]  = err;
    w[STEP_W-1:0]      = step;
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] ack_word(input logic [3:0] op, input logic err,
                                                 input logic [15:0] addr);
    return {ACK_TAG, op, 7'b0, err, addr};
  endfunction

endpackage

// File: rtl/axis_cpu_prog_resp.sv
// Three-stage response pipeline: issues regfile reads, then returns register
// data or a pre-formed status/ack word on cmd_out exactly three cycles later.
module axis_cpu_prog_resp
  import axis_cpu_prog_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  resp_req_t           req_i,
  input  logic [DATA_W-1:0]   reg_rd_data_i,
  output logic                reg_rd_en_o,
  output logic [RADDR_W-1:0]  reg_rd_addr_o,
  output logic [DATA_W-1:0]   cmd_out_data_o,
  output logic                cmd_out_valid_o
);

  resp_req_t          s1_q;
  resp_req_t          s2_q;
  logic               rd_en_q;
  logic [RADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0]  out_data_q;
  logic               out_valid_q;
  logic               rd_req_c;

  assign rd_req_c = req_i.valid && (req_i.kind == RESP_REG);

  // Regfile data arrives while the request sits in stage 2, so it is muxed in there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_q        <= req_i;
      s2_q        <= s1_q;
      rd_en_q     <= rd_req_c;
      if (rd_req_c) rd_addr_q <= req_i.data[RADDR_W-1:0];
      out_valid_q <= s2_q.valid;
      if (s2_q.valid) out_data_q <= (s2_q.kind == RESP_REG) ? reg_rd_data_i : s2_q.data;
    end
  end

  assign reg_rd_en_o     = rd_en_q;
  assign reg_rd_addr_o   = rd_addr_q;
  assign cmd_out_data_o  = out_data_q;
  assign cmd_out_valid_o = out_valid_q;

endmodule

// File: rtl/axis_cpu_prog_ctrl.sv
// Programming and run-control sequencer for the AXI-Stream BPF-style CPU.
// Define AXIS_CPU_PROG_ACK_EN to acknowledge every non-read command beat on cmd_out.
module axis_cpu_prog_ctrl
  import axis_cpu_prog_pkg::*;
#(
  parameter int unsigned CODE_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          cmd_in_TDATA,
  input  logic                       cmd_in_TVALID,
  output logic [DATA_W-1:0]          cmd_out_TDATA,
  output logic                       cmd_out_TVALID,
  output logic                       hold_in_rst,
  output logic                       cpu_en,
  input  logic                       inst_fetch,
  output logic                       inst_wr_en,
  output logic [CODE_ADDR_WIDTH-1:0] inst_wr_addr,
  output logic [7:0]                 inst_wr_data,
  output logic                       imm_wr_en,
  output logic [CODE_ADDR_WIDTH-1:0] imm_wr_addr,
  output logic [DATA_W-1:0]          imm_wr_data,
  output logic                       reg_rd_en,
  output logic [RADDR_W-1:0]         reg_rd_addr,
  input  logic [DATA_W-1:0]          reg_rd_data
);

  state_e                     state_q, state_d;
  logic                       hold_q, hold_d;
  logic                       run_q, run_d;
  logic                       err_q, err_d;
  logic                       cpu_en_q;
  logic [STEP_W-1:0]          step_q, step_d;
  logic [CODE_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                       inst_wr_en_q, inst_wr_en_d;
  logic [CODE_ADDR_WIDTH-1:0] inst_wr_addr_q, inst_wr_addr_d;
  logic [7:0]                 inst_wr_data_q, inst_wr_data_d;
  logic                       imm_wr_en_q, imm_wr_en_d;
  logic [CODE_ADDR_WIDTH-1:0] imm_wr_addr_q, imm_wr_addr_d;
  logic [DATA_W-1:0]          imm_wr_data_q, imm_wr_data_d;
  logic [3:0]                 op_c;
  resp_req_t                  req_c;

  assign op_c = cmd_in_TDATA[31:28];

  // Decode and FSM; command effects override the same-cycle step decrement.
  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    run_d          = run_q;
    err_d          = err_q;
    step_d         = step_q;
    addr_d         = addr_q;
    inst_wr_en_d   = 1'b0;
    inst_wr_addr_d = inst_wr_addr_q;
    inst_wr_data_d = inst_wr_data_q;
    imm_wr_en_d    = 1'b0;
    imm_wr_addr_d  = imm_wr_addr_q;
    imm_wr_data_d  = imm_wr_data_q;
    req_c          = '0;

    if (inst_fetch && !run_q && (step_q != '0)) step_d = step_q - STEP_W'(1);

    if (cmd_in_TVALID) begin
      case (state_q)
        ST_IMM_DATA: begin
          state_d = ST_IDLE;
          if (hold_q) begin
            imm_wr_en_d   = 1'b1;
            imm_wr_addr_d = addr_q;
            imm_wr_data_d = cmd_in_TDATA;
            addr_d        = addr_q + CODE_ADDR_WIDTH'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
          case (op_c)
            OP_NOP: ;
            OP_SET_ADDR: addr_d = cmd_in_TDATA[CODE_ADDR_WIDTH-1:0];
            OP_WR_INST: begin
              if (hold_q) begin
                inst_wr_en_d   = 1'b1;
                inst_wr_addr_d = addr_q;
                inst_wr_data_d = cmd_in_TDATA[7:0];
                addr_d         = addr_q + CODE_ADDR_WIDTH'(1);
              end else begin
                err_d = 1'b1;
              end
            end
            OP_WR_IMM: state_d = ST_IMM_DATA;
            OP_HOLD: begin
              hold_d = cmd_in_TDATA[0];
              if (cmd_in_TDATA[0]) begin
                run_d  = 1'b0;
                step_d = '0;
              end
            end
            OP_STEP: step_d = cmd_in_TDATA[STEP_W-1:0];
            OP_RUN: begin
              run_d = cmd_in_TDATA[0];
              if (!cmd_in_TDATA[0]) step_d = '0;
            end
            OP_READ_REG: begin
              req_c.valid = 1'b1;
              req_c.kind  = RESP_REG;
              req_c.data  = cmd_in_TDATA;
            end
            OP_READ_STATUS: begin
              req_c.valid = 1'b1;
              req_c.kind  = RESP_DATA;
              req_c.data  = status_word(hold_q, run_q, err_q, step_q);
              err_d       = 1'b0;
            end
            default: err_d = 1'b1;
          endcase
        end
      endcase
`ifdef AXIS_CPU_PROG_ACK_EN
      if (!req_c.valid) begin
        req_c.valid = 1'b1;
        req_c.kind  = RESP_DATA;
        req_c.data  = ack_word((state_q == ST_IMM_DATA) ? OP_WR_IMM : op_c, err_d, 16'(addr_d));
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      hold_q         <= 1'b1;
      run_q          <= 1'b0;
      err_q          <= 1'b0;
      step_q         <= '0;
      addr_q         <= '0;
      cpu_en_q       <= 1'b0;
      inst_wr_en_q   <= 1'b0;
      inst_wr_addr_q <= '0;
      inst_wr_data_q <= '0;
      imm_wr_en_q    <= 1'b0;
      imm_wr_addr_q  <= '0;
      imm_wr_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      run_q          <= run_d;
      err_q          <= err_d;
      step_q         <= step_d;
      addr_q         <= addr_d;
      cpu_en_q       <= !hold_d && (run_d || (step_d != '0));
      inst_wr_en_q   <= inst_wr_en_d;
      inst_wr_addr_q <= inst_wr_addr_d;
      inst_wr_data_q <= inst_wr_data_d;
      imm_wr_en_q    <= imm_wr_en_d;
      imm_wr_addr_q  <= imm_wr_addr_d;
      imm_wr_data_q  <= imm_wr_data_d;
    end
  end

  axis_cpu_prog_resp u_resp (
    .clk             (clk),
    .rst_n           (rst),
    .req_i           (req_c),
    .reg_rd_data_i   (reg_rd_data),
    .reg_rd_en_o     (reg_rd_en),
    .reg_rd_addr_o   (reg_rd_addr),
    .cmd_out_data_o  (cmd_out_TDATA),
    .cmd_out_valid_o (cmd_out_TVALID)
  );

  assign hold_in_rst  = hold_q;
  assign cpu_en       = cpu_en_q;
  assign inst_wr_en   = inst_wr_en_q;
  assign inst_wr_addr = inst_wr_addr_q;
  assign inst_wr_data = inst_wr_data_q;
  assign imm_wr_en    = imm_wr_en_q;
  assign imm_wr_addr  = imm_wr_addr_q;
  assign imm_wr_data  = imm_wr_data_q;

endmodule

// File: tb/tb_axis_cpu_prog_ctrl.sv
// Directed bench for axis_cpu_prog_ctrl: behavioural model plus per-cycle compare,
// with literal expectations at key points of each scenario.
module tb_axis_cpu_prog_ctrl;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   cmd_in_TDATA;
  logic          cmd_in_TVALID;
  logic [31:0]   cmd_out_TDATA;
  logic          cmd_out_TVALID;
  logic          hold_in_rst;
  logic          cpu_en;
  logic          inst_fetch;
  logic          inst_wr_en;
  logic [AW-1:0] inst_wr_addr;
  logic [7:0]    inst_wr_data;
  logic          imm_wr_en;
  logic [AW-1:0] imm_wr_addr;
  logic [31:0]   imm_wr_data;
  logic          reg_rd_en;
  logic [3:0]    reg_rd_addr;
  logic [31:0]   reg_rd_data;
  logic          fetch_req;

  always #5 clk = ~clk;

  axis_cpu_prog_ctrl #(.CODE_ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_in_TDATA   (cmd_in_TDATA),
    .cmd_in_TVALID  (cmd_in_TVALID),
    .cmd_out_TDATA  (cmd_out_TDATA),
    .cmd_out_TVALID (cmd_out_TVALID),
    .hold_in_rst    (hold_in_rst),
    .cpu_en         (cpu_en),
    .inst_fetch     (inst_fetch),
    .inst_wr_en     (inst_wr_en),
    .inst_wr_addr   (inst_wr_addr),
    .inst_wr_data   (inst_wr_data),
    .imm_wr_en      (imm_wr_en),
    .imm_wr_addr    (imm_wr_addr),
    .imm_wr_data    (imm_wr_data),
    .reg_rd_en      (reg_rd_en),
    .reg_rd_addr    (reg_rd_addr),
    .reg_rd_data    (reg_rd_data)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] regval(input logic [3:0] i);
    return 32'(i) * 32'h11;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  rsp_t          rq[$];
  int            cyc = 0;
  logic          m_hold, m_run, m_err, m_imm;
  logic [15:0]   m_step;
  logic [AW-1:0] m_addr;
  logic          e_iwe, e_mwe, e_rde, e_cpu;
  logic [AW-1:0] e_iwa, e_mwa;
  logic [7:0]    e_iwd;
  logic [31:0]   e_mwd;
  logic [3:0]    e_rda;

  initial begin : model
    logic [31:0] d;
    logic [3:0]  op;
    logic [31:0] status;
    logic        is_read;
    forever begin
      @(posedge clk);
      cyc++;
      e_iwe = 1'b0;
      e_mwe = 1'b0;
      e_rde = 1'b0;
      if (!rst) begin
        m_hold = 1'b1; m_run = 1'b0; m_err = 1'b0; m_imm = 1'b0;
        m_step = '0;   m_addr = '0;
        rq.delete();
      end else begin
        status = {m_hold, m_run, m_err, 13'b0, m_step};
        if (inst_fetch && !m_run && m_step != 0) m_step = m_step - 16'd1;
        if (cmd_in_TVALID) begin
          d = cmd_in_TDATA;
          op = d[31:28];
          is_read = 1'b0;
          if (m_imm) begin
            m_imm = 1'b0;
            op = 4'd3;
            if (m_hold) begin
              e_mwe = 1'b1; e_mwa = m_addr; e_mwd = d; m_addr = m_addr + 1;
            end else m_err = 1'b1;
          end else begin
            case (op)
              4'd0: ;
              4'd1: m_addr = d[AW-1:0];
              4'd2: if (m_hold) begin
                      e_iwe = 1'b1; e_iwa = m_addr; e_iwd = d[7:0]; m_addr = m_addr + 1;
                    end else m_err = 1'b1;
              4'd3: m_imm = 1'b1;
              4'd4: begin m_hold = d[0]; if (d[0]) begin m_run = 1'b0; m_step = '0; end end
              4'd5: m_step = d[15:0];
              4'd6: begin m_run = d[0]; if (!d[0]) m_step = '0; end
              4'd7: begin
                      is_read = 1'b1; e_rde = 1'b1; e_rda = d[3:0];
                      rq.push_back('{cyc + 2, regval(d[3:0])});
                    end
              4'd8: begin is_read = 1'b1; rq.push_back('{cyc + 2, status}); m_err = 1'b0; end
              default: m_err = 1'b1;
            endcase
          end
`ifdef AXIS_CPU_PROG_ACK_EN
          if (!is_read) rq.push_back('{cyc + 2, {4'hA, op, 7'b0, m_err, 6'b0, m_addr}});
`endif
        end
      end
      e_cpu = !m_hold && (m_run || m_step != 0);
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst && cyc > 0) begin
        chk("hold_in_rst", 32'(hold_in_rst), 32'(m_hold));
        chk("cpu_en", 32'(cpu_en), 32'(e_cpu));
        chk("inst_wr_en", 32'(inst_wr_en), 32'(e_iwe));
        if (e_iwe) begin
          chk("inst_wr_addr", 32'(inst_wr_addr), 32'(e_iwa));
          chk("inst_wr_data", 32'(inst_wr_data), 32'(e_iwd));
        end
        chk("imm_wr_en", 32'(imm_wr_en), 32'(e_mwe));
        if (e_mwe) begin
          chk("imm_wr_addr", 32'(imm_wr_addr), 32'(e_mwa));
          chk("imm_wr_data", imm_wr_data, e_mwd);
        end
        chk("reg_rd_en", 32'(reg_rd_en), 32'(e_rde));
        if (e_rde) chk("reg_rd_addr", 32'(reg_rd_addr), 32'(e_rda));
        if (rq.size() > 0 && rq[0].due == cyc) begin
          chk("cmd_out_TVALID", 32'(cmd_out_TVALID), 32'd1);
          chk("cmd_out_TDATA", cmd_out_TDATA, rq[0].data);
          void'(rq.pop_front());
        end else begin
          chk("cmd_out_TVALID idle", 32'(cmd_out_TVALID), 32'd0);
        end
      end
    end
  end

  // Fetch is gated by cpu_en as the controller would be.
  initial begin : fetcher
    inst_fetch = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      inst_fetch = fetch_req && cpu_en;
    end
  end

  // Regfile: one-cycle read latency; garbage when not reading.
  initial begin : regfile
    logic       pend;
    logic [3:0] pa;
    reg_rd_data = 32'hBAD0_0000;
    forever begin
      @(negedge clk);
      pend = reg_rd_en;
      pa   = reg_rd_addr;
      @(posedge clk);
      #1;
      reg_rd_data = pend ? regval(pa) : 32'hBAD0_0000;
    end
  end

  task automatic beat(input logic [31:0] d);
    cmd_in_TDATA  = d;
    cmd_in_TVALID = 1'b1;
    @(posedge clk);
    #1;
    cmd_in_TVALID = 1'b0;
    cmd_in_TDATA  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int n;
    rst = 1'b1; cmd_in_TDATA = '0; cmd_in_TVALID = 1'b0; fetch_req = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("reset hold", 32'(hold_in_rst), 32'd1);
    chk("reset cpu_en", 32'(cpu_en), 32'd0);
    chk("reset cmd_out_TVALID", 32'(cmd_out_TVALID), 32'd0);
    chk("reset cmd_out_TDATA", cmd_out_TDATA, 32'd0);
    chk("reset wr_en", 32'({inst_wr_en, imm_wr_en, reg_rd_en}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Instruction writes with address auto-increment
    beat(32'h1000_0005);
    beat(32'h2000_003C);
    chk("inst wr0", {inst_wr_en, 13'b0, 6'b0, inst_wr_addr, inst_wr_data}, {1'b1, 13'b0, 6'b0, 10'd5, 8'h3C});
    beat(32'h2000_0011);
    chk("inst wr1", {inst_wr_en, 13'b0, 6'b0, inst_wr_addr, inst_wr_data}, {1'b1, 13'b0, 6'b0, 10'd6, 8'h11});
    chk("cpu_en held", 32'(cpu_en), 32'd0);

    // Immediate writes; data beat is never decoded
    beat(32'h1000_0000);
    beat(32'h3000_0000);
    beat(32'hDEAD_BEEF);
    chk("imm wr en", 32'(imm_wr_en), 32'd1);
    chk("imm wr addr", 32'(imm_wr_addr), 32'd0);
    chk("imm wr data", imm_wr_data, 32'hDEAD_BEEF);
    beat(32'h3000_0000);
    beat(32'h4000_0000);
    chk("imm data not decoded", {imm_wr_data[31:1], hold_in_rst}, 32'h4000_0001);
    chk("imm wr addr1", 32'(imm_wr_addr), 32'd1);

    // Dropped write while running sets err, status read clears it
    beat(32'h4000_0000);
    chk("hold released", 32'(hold_in_rst), 32'd0);
    beat(32'h2000_0055);
    chk("dropped inst wr", 32'(inst_wr_en), 32'd0);
    beat(32'h8000_0000);
    idle(2);
    chk("status err", cmd_out_TDATA, 32'h2000_0000);
    beat(32'h8000_0000);
    idle(2);
    chk("status err cleared", cmd_out_TDATA, 32'h0000_0000);

    // Single-step: exactly three fetches
    fetch_req = 1'b1;
    beat(32'h5000_0003);
    n = 0;
    repeat (8) begin
      if (cpu_en) n++;
      @(posedge clk);
      #1;
    end
    chk("step count", 32'(n), 32'd3);
    beat(32'h5000_0005);
    beat(32'h5000_0002);
    fetch_req = 1'b0;
    beat(32'h8000_0000);
    idle(2);
    chk("step load wins", cmd_out_TDATA, 32'h0000_0002);

    // Back-to-back register reads
    beat(32'h7000_0001);
    chk("reg_rd_en", {reg_rd_en, 27'b0, reg_rd_addr}, {1'b1, 27'b0, 4'd1});
    beat(32'h7000_0002);
    beat(32'h0000_0000);
    chk("reg1 valid", 32'(cmd_out_TVALID), 32'd1);
    chk("reg1 data", cmd_out_TDATA, 32'h0000_0011);
    idle(1);
    chk("reg2 data", cmd_out_TDATA, 32'h0000_0022);
    idle(1);
`ifdef AXIS_CPU_PROG_ACK_EN
    chk("nop ack", cmd_out_TDATA, 32'hA000_0002);
`else
    chk("nop no ack", 32'(cmd_out_TVALID), 32'd0);
`endif

    // Illegal opcode and RUN
    beat(32'h9000_0000);
    beat(32'h6000_0001);
    chk("run cpu_en", 32'(cpu_en), 32'd1);
    beat(32'h8000_0000);
    idle(2);
    chk("status run", cmd_out_TDATA, 32'h6000_0002);

    // Asynchronous reset while a reply is on the bus
    #2 rst = 1'b0;
    #1;
    chk("async hold", 32'(hold_in_rst), 32'd1);
    chk("async cpu_en", 32'(cpu_en), 32'd0);
    chk("async valid", 32'(cmd_out_TVALID), 32'd0);
    idle(2);
    rst = 1'b1;

    // Reset in IMM_DATA discards the header
    beat(32'h3000_0000);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    beat(32'h4000_0000);
    chk("imm header dropped", {imm_wr_en, hold_in_rst}, 32'd0);

    // Address wrap
    beat(32'h4000_0001);
    beat(32'h1000_03FF);
    beat(32'h2000_00AA);
    chk("wrap addr hi", 32'(inst_wr_addr), 32'h3FF);
    beat(32'h2000_00BB);
    chk("wrap addr lo", {inst_wr_en, 23'b0, inst_wr_data}, {1'b1, 23'b0, 8'hBB});
    chk("wrap addr 0", 32'(inst_wr_addr), 32'd0);
    beat(32'hF000_0000);
    beat(32'h8000_0000);
    idle(2);
    chk("status illegal", cmd_out_TDATA, 32'hA000_0000);

    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
